mycpu_store_unit: RTL

//  MEM-stage store path: the write-side counterpart of the WB load-alignment logic. Accepts one store per

---
 rtl/mycpu_store_unit_pkg.sv | 17 +
 rtl/mycpu_store_align.sv | 56 +++++
 rtl/mycpu_store_unit.sv | 78 +++++++
 3 files changed

// File: rtl/mycpu_store_unit_pkg.sv
// mycpu_store_unit_pkg: store-mode encodings, FSM states and bus size codes shared by the store path.
package mycpu_store_unit_pkg;
    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;
    localparam logic [2:0] SZ_L = 3'b011;
    localparam logic [2:0] SZ_R = 3'b100;
    localparam logic [1:0] BUS_BYTE = 2'd0;
    localparam logic [1:0] BUS_HALF = 2'd1;
    localparam logic [1:0] BUS_WORD = 2'd2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} storeStateT;
    // swl/swr strobes are contiguous runs, so the run length picks the bus size
    function automatic logic [1:0] strbSize(input logic [3:0] s);
        return (s == 4'b0001 || s == 4'b1000) ? BUS_BYTE :
               (s == 4'b0011 || s == 4'b1100) ? BUS_HALF : BUS_WORD;
    endfunction
endpackage

// File: rtl/mycpu_store_align.sv
// mycpu_store_align: maps store mode, address and rt data onto byte strobes, lane data, bus size and AdES.
module mycpu_store_align
    import mycpu_store_unit_pkg::*;
#(
    parameter bit ALLOW_UNALIGNED = 1'b0
) (
    input  logic [2:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [1:0]  size,
    output logic [31:0] busAddr,
    output logic        ades
);
    logic [1:0] a;
    assign a = addr[1:0];
    always_comb begin
        wstrb   = 4'b0000;
        wdata   = data;
        size    = BUS_WORD;
        busAddr = addr;
        ades    = 1'b0;
        case (mode)
            SZ_B: begin
                wstrb = 4'b0001 << a;
                wdata = {4{data[7:0]}};
                size  = BUS_BYTE;
            end
            SZ_H: begin
                wstrb = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
                size  = BUS_HALF;
                ades  = a[0] && !ALLOW_UNALIGNED;
            end
            SZ_W: begin
                wstrb = 4'b1111;
                ades  = (a != 2'b00) && !ALLOW_UNALIGNED;
            end
            // ~a == 3-a: swl keeps the high bytes of rt in the low lanes
            SZ_L: begin
                wstrb   = 4'b1111 >> ~a;
                wdata   = data >> {~a, 3'b000};
                size    = strbSize(4'b1111 >> ~a);
                busAddr = {addr[31:2], 2'b00};
            end
            SZ_R: begin
                wstrb   = 4'b1111 << a;
                wdata   = data << {a, 3'b000};
                size    = strbSize(4'b1111 << a);
                busAddr = {addr[31:2], 2'b00};
            end
            default: ades = 1'b1;
        endcase
    end
endmodule

// File: rtl/mycpu_store_unit.sv
// mycpu_store_unit: MEM-stage store path driving the data SRAM-like bus through an IDLE/REQ/WAIT FSM.
module mycpu_store_unit
    import mycpu_store_unit_pkg::*;
#(
    parameter bit ALLOW_UNALIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_mode,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        flush,
    output logic        st_ades,
    output logic        st_done,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok
);
    storeStateT  state, nextState;
    logic [3:0]  alnStrb;
    logic [31:0] alnData, alnAddr;
    logic [1:0]  alnSize;
    logic        alnAdes, accept;

    mycpu_store_align #(.ALLOW_UNALIGNED(ALLOW_UNALIGNED)) u_align (
        .mode    (st_mode),
        .addr    (st_addr),
        .data    (st_data),
        .wstrb   (alnStrb),
        .wdata   (alnData),
        .size    (alnSize),
        .busAddr (alnAddr),
        .ades    (alnAdes)
    );

    assign st_ready     = (state == IDLE) && !flush;
    assign accept       = st_valid && st_ready;
    assign data_sram_wr = 1'b1;

    always_comb begin
        data_sram_req = 1'b0;
        nextState     = state;
        data_sram_req = state == REQ;
        nextState     = state == IDLE ? (accept && !alnAdes ? REQ : IDLE) :
                        state == REQ  ? (data_sram_addr_ok ? WAIT : REQ) :
                                        (data_sram_data_ok ? IDLE : WAIT);
    end

    // bus outputs come only from these registers, never straight from st_*
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            st_ades         <= 1'b0;
            st_done         <= 1'b0;
            data_sram_addr  <= '0;
            data_sram_size  <= '0;
            data_sram_wstrb <= '0;
            data_sram_wdata <= '0;
        end else begin
            state   <= nextState;
            st_ades <= accept && alnAdes;
            st_done <= (state == WAIT) && data_sram_data_ok;
            if (accept && !alnAdes) begin
                data_sram_addr  <= alnAddr;
                data_sram_size  <= alnSize;
                data_sram_wstrb <= alnStrb;
                data_sram_wdata <= alnData;
            end
        end
    end
endmodule
